// File: rtl/tc_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field layout, mode codes and FSM state encoding.
package tc_timer_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_MODE_MSB  = 2;
  localparam int CTRL_IM        = 3;
  localparam int CTRL_W         = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Field order mirrors the CTRL bit positions above (IM at bit 3, En at bit 0).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input tc_ctrl_t c);
    return {{(32 - CTRL_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/tc_timer.sv
// Countdown timer with one-shot / auto-reload modes and a maskable interrupt,
// read and written through a two-bit word offset on the M-stage data bus.
module tc_timer
  import tc_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e   state_q, state_d;
  tc_ctrl_t    ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic        wr_ctrl, wr_preset;
  logic        unused_addr;

  assign wr_ctrl     = WE && (Addr[3:2] == TC_CTRL);
  assign wr_preset   = WE && (Addr[3:2] == TC_PRESET);
  assign unused_addr = ^Addr[31:4];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    // A CPU write to CTRL or PRESET acknowledges a pending interrupt; the FSM
    // below may still override this when it fires on the same edge.
    irq_d    = (wr_ctrl || wr_preset) ? 1'b0 : irq_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q.mode != MODE_ONESHOT) irq_d = 1'b0;
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          irq_d   = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        // Auto-reload drops the flag on the way out so each period gives a
        // single-cycle pulse; every other mode stops the timer and holds it.
        if (ctrl_q.mode == MODE_RELOAD) irq_d = 1'b0;
        else                            ctrl_d.en = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl)   ctrl_d   = tc_ctrl_t'(Din[CTRL_W-1:0]);
    if (wr_preset) preset_d = Din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    Dout = 32'd0;
    unique case (Addr[3:2])
      TC_CTRL:   Dout = ctrl_to_word(ctrl_q);
      TC_PRESET: Dout = preset_q;
      TC_COUNT:  Dout = count_q;
      TC_RSVD:   Dout = 32'd0;
      default:   Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_q & ctrl_q.im;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: a reference model of the register/timer rules
// checked every cycle, plus hand-computed expectations at key points.
module tb_tc_timer;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] Addr  = '0;
  logic        WE    = 1'b0;
  logic [31:0] Din   = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  // Reference model. ph: 0 waiting for En, 1 about to load, 2 counting, 3 just fired.
  logic        m_en = 0, m_im = 0, m_flag = 0;
  logic [1:0]  m_mode = 0;
  logic [31:0] m_preset = 0, m_count = 0;
  int          m_ph = 0;

  logic m_wc, m_wp, m_fire;
  assign m_wc   = WE && (Addr[3:2] == 2'd0);
  assign m_wp   = WE && (Addr[3:2] == 2'd1);
  assign m_fire = (m_ph == 2) && m_en && (m_count <= 32'd1);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en <= 0; m_im <= 0; m_mode <= 0; m_flag <= 0;
      m_preset <= 0; m_count <= 0; m_ph <= 0;
    end else begin
      m_ph <= (m_ph == 0) ? (m_en ? 1 : 0) :
              (m_ph == 1) ? 2 :
              (m_ph == 2) ? (!m_en ? 0 : (m_fire ? 3 : 2)) : 0;
      m_count <= (m_ph == 1) ? m_preset :
                 (m_ph == 2 && m_en) ? ((m_count > 1) ? m_count - 1 : 32'd0) : m_count;
      m_flag <= m_fire ? 1'b1 :
                (m_ph == 3 && m_mode == 2'd1) ? 1'b0 :
                (m_ph == 0 && m_mode != 2'd0) ? 1'b0 :
                (m_wc || m_wp) ? 1'b0 : m_flag;
      m_en   <= m_wc ? Din[0] : ((m_ph == 3 && m_mode != 2'd1) ? 1'b0 : m_en);
      m_mode <= m_wc ? Din[2:1] : m_mode;
      m_im   <= m_wc ? Din[3] : m_im;
      m_preset <= m_wp ? Din : m_preset;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_irq", {31'd0, IRQ}, {31'd0, m_flag & m_im});
    chk("model_dout", Dout, model_rd(Addr[3:2]));
  end

  // All stimulus tasks are entered 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #2;
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'd0, a};
    #1;
    v = Dout;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    @(posedge clk);
    #2;

    // Reset held with clocks running
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      chk("reset_read", v, 32'd0);
      chk("reset_irq", {31'd0, IRQ}, 32'd0);
      step(1);
    end
    reset = 1'b1;
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, v);
    chk("ctrl_mask", v, 32'h0000_000F);
    wr(2'd0, 32'd0);
    step(4);

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      rd(2'd2, v);
      if (k >= 2 && k <= 6) chk("oneshot_count", v, 32'(7 - k));
      if (k == 7) begin
        chk("oneshot_zero", v, 32'd0);
        chk("oneshot_irq", {31'd0, IRQ}, 32'd1);
      end
      if (k == 8) begin
        rd(2'd0, v);
        chk("oneshot_ctrl", v, 32'h8);
        chk("oneshot_irq_hold", {31'd0, IRQ}, 32'd1);
      end
    end
    step(3);
    chk("oneshot_irq_held", {31'd0, IRQ}, 32'd1);
    wr(2'd1, 32'd7);
    chk("oneshot_irq_ack", {31'd0, IRQ}, 32'd0);

    // Auto-reload, PRESET=5, period 8
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      step(1);
      rd(2'd2, v);
      chk("reload_irq", {31'd0, IRQ}, (k == 7 || k == 15 || k == 23) ? 32'd1 : 32'd0);
      if (k == 10) chk("reload_count", v, 32'd5);
    end
    wr(2'd0, 32'd0);
    step(3);

    // Masked interrupt
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    step(6);
    rd(2'd2, v);
    chk("mask_count", v, 32'd0);
    chk("mask_irq", {31'd0, IRQ}, 32'd0);
    rd(2'd0, v);
    chk("mask_ctrl", v, 32'd0);
    wr(2'd0, 32'd0);

    // Pause at COUNT=2, then resume with a reload
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    step(5);
    wr(2'd0, 32'h8);
    rd(2'd2, v);
    chk("pause_count", v, 32'd2);
    step(10);
    rd(2'd2, v);
    chk("pause_hold", v, 32'd2);
    chk("pause_irq", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    rd(2'd2, v);
    chk("resume_reload", v, 32'd6);
    wr(2'd0, 32'd0);
    step(3);

    // PRESET rewritten mid-count, read-only COUNT, reserved offset
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    step(4);
    rd(2'd2, v);
    chk("coll_count3", v, 32'd3);
    wr(2'd1, 32'd9);
    step(2);
    chk("coll_old_irq", {31'd0, IRQ}, 32'd1);
    step(3);
    rd(2'd2, v);
    chk("coll_new_reload", v, 32'd9);
    wr(2'd2, 32'h55);
    rd(2'd2, v);
    chk("count_readonly", v, 32'd8);
    rd(2'd1, v);
    chk("preset_read", v, 32'd9);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    chk("rsvd_read", v, 32'd0);
    wr(2'd0, 32'd0);
    step(3);

    // Asynchronous reset mid-count
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    step(4);
    rd(2'd2, v);
    chk("pre_reset_count", v, 32'd4);
    reset = 1'b0;
    #1;
    chk("async_count", Dout, 32'd0);
    chk("async_irq", {31'd0, IRQ}, 32'd0);
    step(2);
    reset = 1'b1;
    step(5);
    rd(2'd2, v);
    chk("post_reset_count", v, 32'd0);
    rd(2'd0, v);
    chk("post_reset_ctrl", v, 32'd0);
    chk("post_reset_irq", {31'd0, IRQ}, 32'd0);
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
